// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one 32-bit asynchronous SRAM between the IF (fetch) and MEM
// (load/store) pipeline stages, with programmable read/write wait states.
`default_nettype none

module sram_arbiter #(
  parameter int ADDR_W  = 20,
  parameter int RD_WAIT = 1,
  parameter int WR_WAIT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [31:0]       if_rdata_o,
  output logic              if_ack_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [3:0]        mem_be_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_ack_o,
  output logic              stall_req_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_wdata_o,
  input  logic [31:0]       sram_rdata_i,
  output logic              sram_data_oe_o,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  output logic [3:0]        sram_be_n_o
);

  localparam int WAIT_MAX = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CNT_W    = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               last_mem, last_mem_d;
  logic               gnt_mem, gnt_mem_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [31:0]        wdata_d;
  logic               data_oe_d;
  logic               ce_n_d, oe_n_d, we_n_d;
  logic [3:0]         be_n_d;
  logic [31:0]        if_rdata_d, mem_rdata_d;
  logic               if_ack_d, mem_ack_d;
  logic               pick_if, pick_mem;

  // MEM normally wins; IF gets one turn right after a MEM grant so fetch never starves.
  assign pick_if     = if_req_i & (~mem_req_i | last_mem);
  assign pick_mem    = mem_req_i & ~pick_if;
  assign stall_req_o = (if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o);

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    last_mem_d  = last_mem;
    gnt_mem_d   = gnt_mem;
    addr_d      = sram_addr_o;
    wdata_d     = sram_wdata_o;
    data_oe_d   = sram_data_oe_o;
    ce_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    we_n_d      = 1'b1;
    be_n_d      = 4'hF;
    if_rdata_d  = if_rdata_o;
    mem_rdata_d = mem_rdata_o;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_if | pick_mem) begin
          gnt_mem_d  = pick_mem;
          last_mem_d = pick_mem;
          ce_n_d     = 1'b0;
          addr_d     = pick_mem ? mem_addr_i : if_addr_i;
          if (pick_mem & mem_we_i) begin
            state_d   = WR;
            cnt_d     = CNT_W'(WR_WAIT);
            we_n_d    = 1'b0;
            be_n_d    = ~mem_be_i;
            wdata_d   = mem_wdata_i;
            data_oe_d = 1'b1;
          end else begin
            state_d = RD;
            cnt_d   = CNT_W'(RD_WAIT);
            oe_n_d  = 1'b0;
            be_n_d  = 4'h0;
          end
        end
      end
      RD: begin
        if (cnt == '0) begin
          state_d = DONE;
          if (gnt_mem) begin
            mem_rdata_d = sram_rdata_i;
            mem_ack_d   = 1'b1;
          end else begin
            if_rdata_d = sram_rdata_i;
            if_ack_d   = 1'b1;
          end
        end else begin
          cnt_d  = cnt - CNT_W'(1);
          ce_n_d = 1'b0;
          oe_n_d = 1'b0;
          be_n_d = 4'h0;
        end
      end
      WR: begin
        // Data bus stays driven into DONE for hold time after we_n rises.
        if (cnt == '0) begin
          state_d   = DONE;
          mem_ack_d = 1'b1;
        end else begin
          cnt_d  = cnt - CNT_W'(1);
          ce_n_d = 1'b0;
          we_n_d = 1'b0;
          be_n_d = sram_be_n_o;
        end
      end
      DONE: begin
        state_d   = IDLE;
        data_oe_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      cnt            <= '0;
      last_mem       <= 1'b0;
      gnt_mem        <= 1'b0;
      sram_addr_o    <= '0;
      sram_wdata_o   <= '0;
      sram_data_oe_o <= 1'b0;
      sram_ce_n_o    <= 1'b1;
      sram_oe_n_o    <= 1'b1;
      sram_we_n_o    <= 1'b1;
      sram_be_n_o    <= 4'hF;
      if_rdata_o     <= '0;
      mem_rdata_o    <= '0;
      if_ack_o       <= 1'b0;
      mem_ack_o      <= 1'b0;
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      last_mem       <= last_mem_d;
      gnt_mem        <= gnt_mem_d;
      sram_addr_o    <= addr_d;
      sram_wdata_o   <= wdata_d;
      sram_data_oe_o <= data_oe_d;
      sram_ce_n_o    <= ce_n_d;
      sram_oe_n_o    <= oe_n_d;
      sram_we_n_o    <= we_n_d;
      sram_be_n_o    <= be_n_d;
      if_rdata_o     <= if_rdata_d;
      mem_rdata_o    <= mem_rdata_d;
      if_ack_o       <= if_ack_d;
      mem_ack_o      <= mem_ack_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed self-checking bench for sram_arbiter (default and RD_WAIT=3/WR_WAIT=0).
`default_nettype none

module tb_sram_arbiter;

  localparam logic [31:0] V10 = 32'h34011100;
  localparam logic [31:0] V30 = 32'hA5A50030;
  localparam logic [31:0] V40 = 32'h5A5A0040;

  int tests = 0;
  int fails = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // default-parameter instance
  logic        if_req = 0, mem_req = 0, mem_we = 0;
  logic [19:0] if_addr = 0, mem_addr = 0;
  logic [3:0]  mem_be = 0;
  logic [31:0] mem_wdata = 0;
  logic [31:0] if_rdata, mem_rdata, s_wdata, s_rdata;
  logic        if_ack, mem_ack, stall, s_doe, s_ce_n, s_oe_n, s_we_n;
  logic [19:0] s_addr;
  logic [3:0]  s_be_n;
  logic [31:0] sram [0:255];

  sram_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ack_o(if_ack),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_be_i(mem_be), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata), .mem_ack_o(mem_ack),
    .stall_req_o(stall), .sram_addr_o(s_addr), .sram_wdata_o(s_wdata), .sram_rdata_i(s_rdata),
    .sram_data_oe_o(s_doe), .sram_ce_n_o(s_ce_n), .sram_oe_n_o(s_oe_n), .sram_we_n_o(s_we_n),
    .sram_be_n_o(s_be_n)
  );

  assign s_rdata = sram[s_addr[7:0]];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) sram[i] <= 32'h0;
      sram[8'h10] <= V10;
      sram[8'h30] <= V30;
      sram[8'h40] <= V40;
    end else if (!s_ce_n && !s_we_n) begin
      for (int b = 0; b < 4; b++)
        if (!s_be_n[b]) sram[s_addr[7:0]][8*b +: 8] <= s_wdata[8*b +: 8];
    end
  end

  // RD_WAIT=3 / WR_WAIT=0 instance
  logic        p_if_req = 0, p_mem_req = 0, p_mem_we = 0;
  logic [19:0] p_if_addr = 0, p_mem_addr = 0;
  logic [3:0]  p_mem_be = 0;
  logic [31:0] p_mem_wdata = 0;
  logic [31:0] p_if_rdata, p_mem_rdata, p_wdata, p_rdata;
  logic        p_if_ack, p_mem_ack, p_stall, p_doe, p_ce_n, p_oe_n, p_we_n;
  logic [19:0] p_addr;
  logic [3:0]  p_be_n;
  logic [31:0] sram2 [0:255];

  sram_arbiter #(.ADDR_W(20), .RD_WAIT(3), .WR_WAIT(0)) dut2 (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(p_if_req), .if_addr_i(p_if_addr), .if_rdata_o(p_if_rdata), .if_ack_o(p_if_ack),
    .mem_req_i(p_mem_req), .mem_we_i(p_mem_we), .mem_be_i(p_mem_be), .mem_addr_i(p_mem_addr),
    .mem_wdata_i(p_mem_wdata), .mem_rdata_o(p_mem_rdata), .mem_ack_o(p_mem_ack),
    .stall_req_o(p_stall), .sram_addr_o(p_addr), .sram_wdata_o(p_wdata), .sram_rdata_i(p_rdata),
    .sram_data_oe_o(p_doe), .sram_ce_n_o(p_ce_n), .sram_oe_n_o(p_oe_n), .sram_we_n_o(p_we_n),
    .sram_be_n_o(p_be_n)
  );

  assign p_rdata = sram2[p_addr[7:0]];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) sram2[i] <= 32'h0;
      sram2[8'h10] <= V10;
    end else if (!p_ce_n && !p_we_n) begin
      for (int b = 0; b < 4; b++)
        if (!p_be_n[b]) sram2[p_addr[7:0]][8*b +: 8] <= p_wdata[8*b +: 8];
    end
  end

  // Waits (bounded) for the selected ack on the default instance; n = negedges until ack, -1 on timeout.
  task automatic wait_ack(input bit want_mem, output int n, output int oe_low, output int we_low,
                          output bit stall_ok, output logic [3:0] be_seen);
    n = -1; oe_low = 0; we_low = 0; stall_ok = 1'b1; be_seen = 4'hx;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (!s_oe_n) oe_low++;
      if (!s_we_n) we_low++;
      if (!s_ce_n) be_seen = s_be_n;
      if (want_mem ? mem_ack : if_ack) begin n = i; break; end
      if (!stall) stall_ok = 1'b0;
    end
  endtask

  task automatic wait_ack2(input bit want_mem, output int n, output int oe_low, output int we_low);
    n = -1; oe_low = 0; we_low = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (!p_oe_n) oe_low++;
      if (!p_we_n) we_low++;
      if (want_mem ? p_mem_ack : p_if_ack) begin n = i; break; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++; if ({s_ce_n, s_oe_n, s_we_n, s_be_n, s_doe} !== 8'b1111_1110) begin fails++; $display("FAIL reset_strobes: got %b want 11111110", {s_ce_n, s_oe_n, s_we_n, s_be_n, s_doe}); end
    tests++; if ({s_addr, s_wdata} !== 52'h0) begin fails++; $display("FAIL reset_addr_wdata: got %h want 0", {s_addr, s_wdata}); end
    tests++; if ({if_rdata, mem_rdata, if_ack, mem_ack, stall} !== 67'h0) begin fails++; $display("FAIL reset_resp: got %h want 0", {if_rdata, mem_rdata, if_ack, mem_ack, stall}); end
    rst = 1'b0;
    @(negedge clk);
    tests++; if ({s_ce_n, s_oe_n, s_we_n, if_ack, mem_ack} !== 5'b11100) begin fails++; $display("FAIL reset_idle: got %b want 11100", {s_ce_n, s_oe_n, s_we_n, if_ack, mem_ack}); end
  endtask

  task automatic test_fetch();
    int n, oe, we; bit sok; logic [3:0] be;
    if_req = 1'b1; if_addr = 20'h00010;
    #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL fetch_stall_req: got %b want 1", stall); end
    wait_ack(1'b0, n, oe, we, sok, be);
    tests++; if (n !== 3) begin fails++; $display("FAIL fetch_ack_pos: got %0d want 3", n); end
    tests++; if (oe !== 2) begin fails++; $display("FAIL fetch_oe_cycles: got %0d want 2", oe); end
    tests++; if (sok !== 1'b1) begin fails++; $display("FAIL fetch_stall_hold: got %b want 1", sok); end
    tests++; if (be !== 4'h0) begin fails++; $display("FAIL fetch_be_n: got %b want 0000", be); end
    tests++; if (if_rdata !== V10) begin fails++; $display("FAIL fetch_rdata: got %h want %h", if_rdata, V10); end
    tests++; if ({stall, mem_ack, s_oe_n, s_ce_n} !== 4'b0011) begin fails++; $display("FAIL fetch_ack_cycle: got %b want 0011", {stall, mem_ack, s_oe_n, s_ce_n}); end
    if_req = 1'b0;
    @(negedge clk);
    tests++; if ({if_ack, if_rdata} !== {1'b0, V10}) begin fails++; $display("FAIL fetch_after: got %h want %h", {if_ack, if_rdata}, {1'b0, V10}); end
  endtask

  task automatic test_store_load();
    int n, oe, we; bit sok; logic [3:0] be;
    mem_req = 1'b1; mem_we = 1'b1; mem_be = 4'b0011; mem_addr = 20'h00020; mem_wdata = 32'hDEADBEEF;
    wait_ack(1'b1, n, oe, we, sok, be);
    tests++; if (n !== 3) begin fails++; $display("FAIL store_ack_pos: got %0d want 3", n); end
    tests++; if (we !== 2 || oe !== 0) begin fails++; $display("FAIL store_strobes: got we=%0d oe=%0d want we=2 oe=0", we, oe); end
    tests++; if (be !== 4'b1100) begin fails++; $display("FAIL store_be_n: got %b want 1100", be); end
    tests++; if ({s_doe, s_we_n, s_wdata} !== {2'b11, 32'hDEADBEEF}) begin fails++; $display("FAIL store_hold: got %h want %h", {s_doe, s_we_n, s_wdata}, {2'b11, 32'hDEADBEEF}); end
    mem_req = 1'b0;
    @(negedge clk);
    tests++; if ({s_doe, mem_ack} !== 2'b00) begin fails++; $display("FAIL store_release: got %b want 00", {s_doe, mem_ack}); end
    mem_req = 1'b1; mem_we = 1'b0;
    wait_ack(1'b1, n, oe, we, sok, be);
    tests++; if (n !== 3 || oe !== 2) begin fails++; $display("FAIL load_timing: got n=%0d oe=%0d want 3/2", n, oe); end
    tests++; if (mem_rdata !== 32'h0000BEEF) begin fails++; $display("FAIL load_rdata: got %h want 0000beef", mem_rdata); end
    mem_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store_be0();
    int n, oe, we; bit sok; logic [3:0] be;
    mem_req = 1'b1; mem_we = 1'b1; mem_be = 4'b0000; mem_addr = 20'h00020; mem_wdata = 32'hFFFFFFFF;
    wait_ack(1'b1, n, oe, we, sok, be);
    tests++; if (n !== 3 || we !== 2) begin fails++; $display("FAIL be0_timing: got n=%0d we=%0d want 3/2", n, we); end
    tests++; if (be !== 4'hF) begin fails++; $display("FAIL be0_be_n: got %b want 1111", be); end
    mem_req = 1'b0;
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0;
    wait_ack(1'b1, n, oe, we, sok, be);
    tests++; if (mem_rdata !== 32'h0000BEEF) begin fails++; $display("FAIL be0_unchanged: got %h want 0000beef", mem_rdata); end
    mem_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_arbitration();
    int n, oe, we; bit sok; logic [3:0] be;
    int mem_acks, if_acks;
    if_req = 1'b1; if_addr = 20'h00010;
    wait_ack(1'b0, n, oe, we, sok, be);
    tests++; if (n !== 3) begin fails++; $display("FAIL arb_prefetch: got %0d want 3", n); end
    if_req = 1'b0;
    @(negedge clk);
    mem_acks = 0; if_acks = 0;
    if_req = 1'b1; if_addr = 20'h00010;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 20'h00030;
    for (int t = 1; t <= 14; t++) begin
      @(negedge clk);
      tests++; if (if_ack && mem_ack) begin fails++; $display("FAIL arb_dual_ack: got both at t=%0d want one", t); end
      if (mem_ack) begin
        mem_acks++;
        if (mem_acks == 1) begin
          tests++; if (t !== 3 || mem_rdata !== V30) begin fails++; $display("FAIL arb_mem1: got t=%0d %h want t=3 %h", t, mem_rdata, V30); end
          mem_addr = 20'h00040;
        end else begin
          tests++; if (t !== 11 || mem_rdata !== V40) begin fails++; $display("FAIL arb_mem2: got t=%0d %h want t=11 %h", t, mem_rdata, V40); end
          mem_req = 1'b0;
        end
      end
      if (if_ack) begin
        if_acks++;
        tests++; if (t !== 7 || if_rdata !== V10) begin fails++; $display("FAIL arb_if: got t=%0d %h want t=7 %h", t, if_rdata, V10); end
        if_req = 1'b0;
      end
    end
    tests++; if (mem_acks !== 2 || if_acks !== 1) begin fails++; $display("FAIL arb_counts: got mem=%0d if=%0d want 2/1", mem_acks, if_acks); end
    mem_req = 1'b0; if_req = 1'b0;
  endtask

  task automatic test_input_change();
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 20'h00030;
    @(negedge clk);
    tests++; if ({s_oe_n, s_addr} !== {1'b0, 20'h00030}) begin fails++; $display("FAIL chg_rd_start: got %h want 000030", {s_oe_n, s_addr}); end
    mem_addr = 20'h00040;
    @(negedge clk);
    tests++; if (s_addr !== 20'h00030) begin fails++; $display("FAIL chg_addr_held: got %h want 00030", s_addr); end
    @(negedge clk);
    tests++; if ({mem_ack, mem_rdata} !== {1'b1, V30}) begin fails++; $display("FAIL chg_rdata: got %h want %h", {mem_ack, mem_rdata}, {1'b1, V30}); end
    mem_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_rd();
    int n, oe, we; bit sok; logic [3:0] be;
    if_req = 1'b1; if_addr = 20'h00010;
    @(negedge clk);
    tests++; if (s_oe_n !== 1'b0) begin fails++; $display("FAIL rst_mid_in_rd: got %b want 0", s_oe_n); end
    #2 rst = 1'b1;
    #1;
    tests++; if ({s_ce_n, s_oe_n, if_ack, if_rdata} !== {3'b110, 32'h0}) begin fails++; $display("FAIL rst_mid_async: got %h want %h", {s_ce_n, s_oe_n, if_ack, if_rdata}, {3'b110, 32'h0}); end
    if_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      tests++; if ({if_ack, s_ce_n} !== 2'b01) begin fails++; $display("FAIL rst_mid_no_ack: got %b want 01", {if_ack, s_ce_n}); end
    end
    rst = 1'b0;
    @(negedge clk);
    if_req = 1'b1;
    wait_ack(1'b0, n, oe, we, sok, be);
    tests++; if (n !== 3 || if_rdata !== V10) begin fails++; $display("FAIL rst_mid_refetch: got n=%0d %h want 3 %h", n, if_rdata, V10); end
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_param_sweep();
    int n, oe, we;
    p_mem_req = 1'b1; p_mem_we = 1'b1; p_mem_be = 4'hF; p_mem_addr = 20'h00050; p_mem_wdata = 32'h12345678;
    wait_ack2(1'b1, n, oe, we);
    tests++; if (n !== 2 || we !== 1) begin fails++; $display("FAIL sweep_write: got n=%0d we=%0d want 2/1", n, we); end
    p_mem_req = 1'b0;
    @(negedge clk);
    p_mem_req = 1'b1; p_mem_we = 1'b0;
    wait_ack2(1'b1, n, oe, we);
    tests++; if (n !== 5 || oe !== 4) begin fails++; $display("FAIL sweep_read_timing: got n=%0d oe=%0d want 5/4", n, oe); end
    tests++; if (p_mem_rdata !== 32'h12345678) begin fails++; $display("FAIL sweep_read_data: got %h want 12345678", p_mem_rdata); end
    p_mem_req = 1'b0;
    @(negedge clk);
    p_if_req = 1'b1; p_if_addr = 20'h00010;
    wait_ack2(1'b0, n, oe, we);
    tests++; if (n !== 5 || p_if_rdata !== V10 || p_stall !== 1'b0) begin fails++; $display("FAIL sweep_fetch: got n=%0d %h stall=%b want 5 %h 0", n, p_if_rdata, p_stall, V10); end
    p_if_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_fetch();
    test_store_load();
    test_store_be0();
    test_arbitration();
    test_input_change();
    test_reset_mid_rd();
    test_param_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
